ex_muldiv_stage: RTL and testbench

- Parametrised next-generation execute stage for the 5-stage RISC-V pipeline. Sits between the ID/EX and EX/MEM pipeline registers.
- Keeps the existing datapath: operand forwarding, ALU control decode, single-cycle integer ALU and branch-target adder.
- Adds the RV32M multiply/divide/remainder ops, run on an iterative multi-cycle unit.
- Raises a stall to the hazard unit while a multi-cycle op is in flight.

---
 rtl/ex_muldiv_stage.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage of the 5-stage RV32 pipeline with RV32M support.
//
// Combinational datapath: operand forwarding, ALU control decode, integer ALU and
// branch-target adder. RV32M ops (aluop 10, funct7 0000001) run on an iterative
// shift-add / restoring-divide unit. The stage raises stall_ex to the hazard unit
// while an M-op is in flight.
//
// Optional build macro: EX_FAST_MUL_EN
//   defined   - MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN product (1-cycle stall)
//   undefined - every M-op is iterative, no wide multiplier is inferred
//
// Ports:
//   clk, reset          pipeline clock, synchronous active-high reset
//   valid_in            ID/EX holds a live instruction
//   imm_ex, pc_ex       immediate and instruction PC
//   reg_data1_ex/2_ex   register file operands
//   funct3_ex/7_ex      instruction function fields
//   aluop_ex, alusrc_ex ALU op class and operand-B select
//   forward_a/b         forward selects (00 regfile, 01 WB, 10 MEM, 11 zero)
//   alu_data_wb         WB-stage forward value
//   alu_out_mem         MEM-stage forward value
//   zero_ex             alu_out_ex == 0
//   alu_out_ex          execute result (partial accumulator while stalled)
//   pc_branch_ex        pc_ex + imm_ex
//   reg_data2_final_ex  forwarded rs2 (store data)
//   valid_out           alu_out_ex is the final result for this instruction
//   stall_ex            freeze front end, bubble into EX/MEM

module ex_muldiv_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [XLEN-1:0] imm_ex,
   input  logic [XLEN-1:0] reg_data1_ex,
   input  logic [XLEN-1:0] reg_data2_ex,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [2:0]      funct3_ex,
   input  logic [6:0]      funct7_ex,
   input  logic [1:0]      aluop_ex,
   input  logic            alusrc_ex,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic [XLEN-1:0] alu_data_wb,
   input  logic [XLEN-1:0] alu_out_mem,
   output logic            zero_ex,
   output logic [XLEN-1:0] alu_out_ex,
   output logic [XLEN-1:0] pc_branch_ex,
   output logic [XLEN-1:0] reg_data2_final_ex,
   output logic            valid_out,
   output logic            stall_ex
);

   localparam int unsigned SHW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   // ------------------------------------------------------------------
   // Forwarding and operand select
   // ------------------------------------------------------------------
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b_fwd;
   logic [XLEN-1:0] op_b;

   always_comb begin
      case (forward_a)
         2'b00:   op_a = reg_data1_ex;
         2'b01:   op_a = alu_data_wb;
         2'b10:   op_a = alu_out_mem;
         default: op_a = '0;
      endcase
      case (forward_b)
         2'b00:   op_b_fwd = reg_data2_ex;
         2'b01:   op_b_fwd = alu_data_wb;
         2'b10:   op_b_fwd = alu_out_mem;
         default: op_b_fwd = '0;
      endcase
   end

   assign op_b               = alusrc_ex ? imm_ex : op_b_fwd;
   assign reg_data2_final_ex = op_b_fwd;
   assign pc_branch_ex       = pc_ex + imm_ex;

   // ------------------------------------------------------------------
   // Single-cycle integer ALU
   // ------------------------------------------------------------------
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;

   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_res = op_a + op_b;
      case (aluop_ex)
         2'b01: alu_res = op_a - op_b;
         2'b10: begin
            case (funct3_ex)
               // funct7[5] selects SUB only for R-type; I-type carries immediate bits there
               3'b000: alu_res = (funct7_ex[5] && !alusrc_ex) ? (op_a - op_b) : (op_a + op_b);
               3'b001: alu_res = op_a << shamt;
               3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
               3'b100: alu_res = op_a ^ op_b;
               3'b101: alu_res = funct7_ex[5] ? $unsigned($signed(op_a) >>> shamt)
                                              : (op_a >> shamt);
               3'b110: alu_res = op_a | op_b;
               default: alu_res = op_a & op_b;
            endcase
         end
         default: alu_res = op_a + op_b;
      endcase
   end

   // ------------------------------------------------------------------
   // M-op decode and operand preparation
   // ------------------------------------------------------------------
   logic            m_op;
   logic            a_signed;
   logic            b_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            div_ovf;

   assign m_op     = valid_in && (aluop_ex == 2'b10) && (funct7_ex == 7'b0000001);
   // Unsigned-rs1 forms: MULHU, DIVU, REMU. rs2 is additionally unsigned for MULHSU.
   assign a_signed = (funct3_ex != 3'b011) && (funct3_ex != 3'b101) && (funct3_ex != 3'b111);
   assign b_signed = a_signed && (funct3_ex != 3'b010);
   assign a_neg    = a_signed && op_a[XLEN-1];
   assign b_neg    = b_signed && op_b[XLEN-1];
   assign a_mag    = a_neg ? ('0 - op_a) : op_a;
   assign b_mag    = b_neg ? ('0 - op_b) : op_b;
   assign div_zero = funct3_ex[2] && (op_b == '0);
   assign div_ovf  = funct3_ex[2] && !funct3_ex[0] &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

   // ------------------------------------------------------------------
   // Iterative unit state
   //   lo_q    : multiplier (shifts out LSB first) / dividend -> quotient
   //   hi_q    : product high half with carry bit / partial remainder
   //   mcand_q : multiplicand / divisor magnitude
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  mcand_q, mcand_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN:0]    hi_q, hi_d;
   logic [2:0]       f3_q, f3_d;
   logic             neg_q, neg_d;
   logic             neg_rem_q, neg_rem_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         mcand_q   <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         f3_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         f3_q      <= f3_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // One shift-add multiply step: conditionally add, then shift {hi, lo} right.
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   mul_sel;
   logic [XLEN:0]   mul_hi_n;
   logic [XLEN-1:0] mul_lo_n;

   assign mul_sum  = hi_q + {1'b0, mcand_q};
   assign mul_sel  = lo_q[0] ? mul_sum : hi_q;
   assign mul_hi_n = {1'b0, mul_sel[XLEN:1]};
   assign mul_lo_n = {mul_sel[0], lo_q[XLEN-1:1]};

   // One restoring-divide step: shift next dividend bit in, subtract if it fits.
   logic [XLEN:0]   div_sh;
   logic [XLEN:0]   div_diff;
   logic            div_ge;
   logic [XLEN:0]   div_hi_n;
   logic [XLEN-1:0] div_lo_n;

   assign div_sh   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, mcand_q};
   assign div_ge   = (div_sh >= {1'b0, mcand_q});
   assign div_hi_n = div_ge ? div_diff : div_sh;
   assign div_lo_n = {lo_q[XLEN-2:0], div_ge};

   // ------------------------------------------------------------------
   // Result fix-up
   // ------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_mag;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   m_result;

`ifdef EX_FAST_MUL_EN
   assign prod_mag = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, lo_q};
`else
   assign prod_mag = {hi_q[XLEN-1:0], lo_q};
`endif
   assign prod = neg_q ? ('0 - prod_mag) : prod_mag;
   assign quo  = neg_q ? ('0 - lo_q) : lo_q;
   assign rem  = neg_rem_q ? ('0 - hi_q[XLEN-1:0]) : hi_q[XLEN-1:0];

   always_comb begin
      case (f3_q)
         3'b000:         m_result = prod[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:         m_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101: m_result = quo;
         default:        m_result = rem;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------
   logic stall_c;
   logic valid_c;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      f3_d       = f3_q;
      neg_d      = neg_q;
      neg_rem_d  = neg_rem_q;
      stall_c    = 1'b0;
      valid_c    = 1'b0;
      alu_out_ex = alu_res;

      unique case (state_q)
         StIdle: begin
            valid_c = valid_in && !m_op;
            if (m_op) begin
               stall_c    = 1'b1;
               alu_out_ex = '0;
               f3_d       = funct3_ex;
               mcand_d    = b_mag;
               lo_d       = a_mag;
               hi_d       = '0;
               cnt_d      = '0;
               neg_d      = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               state_d    = StBusy;
               // Special divides preload quotient (lo) and remainder (hi) unsigned.
               if (div_zero) begin
                  lo_d      = '1;
                  hi_d      = {1'b0, op_a};
                  neg_d     = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = StDone;
               end else if (div_ovf) begin
                  lo_d      = op_a;
                  hi_d      = '0;
                  neg_d     = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = StDone;
               end
`ifdef EX_FAST_MUL_EN
               else if (!funct3_ex[2]) begin
                  state_d = StDone;
               end
`endif
            end
         end
         StBusy: begin
            stall_c    = 1'b1;
            alu_out_ex = hi_q[XLEN-1:0];
            cnt_d      = cnt_q + CNT_W'(1);
            if (f3_q[2]) begin
               hi_d = div_hi_n;
               lo_d = div_lo_n;
            end else begin
               hi_d = mul_hi_n;
               lo_d = mul_lo_n;
            end
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            valid_c    = 1'b1;
            alu_out_ex = m_result;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign stall_ex  = stall_c && !reset;
   assign valid_out = valid_c && !reset;
   assign zero_ex   = (alu_out_ex == '0);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage (XLEN=32). Stimulus pushes expected results;
// a monitor pops and compares whenever valid_out is high.
module tb_ex_muldiv_stage;

   localparam int unsigned XLEN = 32;
`ifdef EX_FAST_MUL_EN
   localparam int MUL_STALL = 1;
`else
   localparam int MUL_STALL = 33;
`endif
   localparam int DIV_STALL = 33;

   logic            clk;
   logic            reset;
   logic            valid_in;
   logic [XLEN-1:0] imm_ex;
   logic [XLEN-1:0] reg_data1_ex;
   logic [XLEN-1:0] reg_data2_ex;
   logic [XLEN-1:0] pc_ex;
   logic [2:0]      funct3_ex;
   logic [6:0]      funct7_ex;
   logic [1:0]      aluop_ex;
   logic            alusrc_ex;
   logic [1:0]      forward_a;
   logic [1:0]      forward_b;
   logic [XLEN-1:0] alu_data_wb;
   logic [XLEN-1:0] alu_out_mem;
   logic            zero_ex;
   logic [XLEN-1:0] alu_out_ex;
   logic [XLEN-1:0] pc_branch_ex;
   logic [XLEN-1:0] reg_data2_final_ex;
   logic            valid_out;
   logic            stall_ex;

   ex_muldiv_stage #(.XLEN(XLEN)) dut (
      .clk                (clk),
      .reset              (reset),
      .valid_in           (valid_in),
      .imm_ex             (imm_ex),
      .reg_data1_ex       (reg_data1_ex),
      .reg_data2_ex       (reg_data2_ex),
      .pc_ex              (pc_ex),
      .funct3_ex          (funct3_ex),
      .funct7_ex          (funct7_ex),
      .aluop_ex           (aluop_ex),
      .alusrc_ex          (alusrc_ex),
      .forward_a          (forward_a),
      .forward_b          (forward_b),
      .alu_data_wb        (alu_data_wb),
      .alu_out_mem        (alu_out_mem),
      .zero_ex            (zero_ex),
      .alu_out_ex         (alu_out_ex),
      .pc_branch_ex       (pc_branch_ex),
      .reg_data2_final_ex (reg_data2_final_ex),
      .valid_out          (valid_out),
      .stall_ex           (stall_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] mon_exp;
   string       mon_name;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every presented result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got 0x%08h, expected no result", alu_out_ex);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check(mon_name, alu_out_ex, mon_exp);
            check({mon_name, "_zero"}, {31'b0, zero_ex}, {31'b0, (mon_exp == 32'h0)});
         end
      end
   end

   task automatic idle_inputs();
      valid_in     = 1'b0;
      aluop_ex     = 2'b00;
      funct7_ex    = 7'h00;
      funct3_ex    = 3'h0;
      alusrc_ex    = 1'b0;
      forward_a    = 2'b00;
      forward_b    = 2'b00;
      imm_ex       = '0;
      reg_data1_ex = '0;
      reg_data2_ex = '0;
      pc_ex        = 32'h100;
      alu_data_wb  = '0;
      alu_out_mem  = '0;
   endtask

   task automatic issue_base(input string name, input logic [1:0] aop, input logic [6:0] f7,
                             input logic [2:0] f3, input logic [1:0] fa, input logic [1:0] fb,
                             input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [31:0] wb,
                             input logic [31:0] mem, input logic [31:0] exp);
      logic [31:0] exp_rs2;
      @(posedge clk);
      #1;
      valid_in = 1'b1; aluop_ex = aop; funct7_ex = f7; funct3_ex = f3;
      forward_a = fa; forward_b = fb; alusrc_ex = src;
      reg_data1_ex = rs1; reg_data2_ex = rs2; imm_ex = imm;
      alu_data_wb = wb; alu_out_mem = mem; pc_ex = 32'h100;
      exp_q.push_back(exp);
      name_q.push_back(name);
      case (fb)
         2'b00:   exp_rs2 = rs2;
         2'b01:   exp_rs2 = wb;
         2'b10:   exp_rs2 = mem;
         default: exp_rs2 = 32'h0;
      endcase
      @(negedge clk);
      check({name, "_stall"}, {31'b0, stall_ex}, 32'h0);
      check({name, "_rs2_final"}, reg_data2_final_ex, exp_rs2);
      check({name, "_pc_branch"}, pc_branch_ex, 32'h100 + imm);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic issue_mop(input string name, input logic [2:0] f3, input logic [1:0] fa,
                            input logic [31:0] rs1, input logic [31:0] mem,
                            input logic [31:0] rs2, input logic [31:0] exp,
                            input int exp_stall, input bit poke);
      int n;
      @(posedge clk);
      #1;
      valid_in = 1'b1; aluop_ex = 2'b10; funct7_ex = 7'b0000001; funct3_ex = f3;
      forward_a = fa; forward_b = 2'b00; alusrc_ex = 1'b0;
      reg_data1_ex = rs1; reg_data2_ex = rs2; alu_out_mem = mem;
      exp_q.push_back(exp);
      name_q.push_back(name);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!stall_ex) break;
         n++;
         if (poke && n == 5) alu_out_mem = 32'h1234_5678;
      end
      check({name, "_stall_cycles"}, n, exp_stall);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", {31'b0, stall_ex}, 32'h0);
      check("reset_valid", {31'b0, valid_out}, 32'h0);
      check("reset_zero", {31'b0, zero_ex}, 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Base ALU ops: name, aluop, f7, f3, fa, fb, alusrc, rs1, rs2, imm, wb, mem, expected
      issue_base("add_fwd_mem", 2'b00, 7'h00, 3'd0, 2'b10, 2'b00, 1'b0,
                 32'hDEAD, 32'd7, 32'hFFFF_FFF8, 32'h0, 32'd5, 32'd12);
      issue_base("sub_aluop01", 2'b01, 7'h00, 3'd0, 2'b00, 2'b00, 1'b0,
                 32'd10, 32'd3, 32'h0, 32'h0, 32'h0, 32'd7);
      issue_base("sub_r", 2'b10, 7'h20, 3'd0, 2'b00, 2'b00, 1'b0,
                 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE);
      issue_base("sll_mask", 2'b10, 7'h00, 3'd1, 2'b00, 2'b00, 1'b0,
                 32'd1, 32'h24, 32'h0, 32'h0, 32'h0, 32'h10);
      issue_base("sra", 2'b10, 7'h20, 3'd5, 2'b00, 2'b00, 1'b0,
                 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 32'hF800_0000);
      issue_base("srl", 2'b10, 7'h00, 3'd5, 2'b00, 2'b00, 1'b0,
                 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 32'h0800_0000);
      issue_base("slt", 2'b10, 7'h00, 3'd2, 2'b00, 2'b00, 1'b0,
                 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0, 32'd1);
      issue_base("sltu", 2'b10, 7'h00, 3'd3, 2'b00, 2'b00, 1'b0,
                 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0, 32'd0);
      issue_base("xor", 2'b10, 7'h00, 3'd4, 2'b00, 2'b00, 1'b0,
                 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 32'h0FF0);
      issue_base("or", 2'b10, 7'h00, 3'd6, 2'b00, 2'b00, 1'b0,
                 32'hF0, 32'h0F, 32'h0, 32'h0, 32'h0, 32'hFF);
      issue_base("and", 2'b10, 7'h00, 3'd7, 2'b00, 2'b00, 1'b0,
                 32'hF0, 32'h3C, 32'h0, 32'h0, 32'h0, 32'h30);
      issue_base("addi_neg", 2'b10, 7'h7F, 3'd0, 2'b00, 2'b00, 1'b1,
                 32'd100, 32'd55, 32'hFFFF_FFF6, 32'h0, 32'h0, 32'd90);
      issue_base("fwd_zero_a_wb_b", 2'b00, 7'h00, 3'd0, 2'b11, 2'b01, 1'b0,
                 32'h55, 32'h66, 32'h0, 32'd9, 32'h0, 32'd9);
      issue_base("add_to_zero", 2'b00, 7'h00, 3'd0, 2'b00, 2'b00, 1'b0,
                 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'd0);

      // M-ops: name, funct3, fa, rs1, mem, rs2, expected, stall cycles, poke mem mid-stall
      issue_mop("mul_6_m7", 3'd0, 2'b00, 32'd6, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFD6,
                MUL_STALL, 1'b0);
      issue_mop("mul_3_4", 3'd0, 2'b00, 32'd3, 32'h0, 32'd4, 32'd12, MUL_STALL, 1'b0);
      issue_mop("mulhu_max", 3'd3, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, MUL_STALL, 1'b0);
      issue_mop("mulh_min_min", 3'd1, 2'b00, 32'h8000_0000, 32'h0, 32'h8000_0000,
                32'h4000_0000, MUL_STALL, 1'b0);
      issue_mop("mulhsu_m1_2", 3'd2, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'd2,
                32'hFFFF_FFFF, MUL_STALL, 1'b0);
      issue_mop("div_m20_3_poke", 3'd4, 2'b10, 32'h0, 32'hFFFF_FFEC, 32'd3,
                32'hFFFF_FFFA, DIV_STALL, 1'b1);
      issue_mop("rem_m20_3_poke", 3'd6, 2'b10, 32'h0, 32'hFFFF_FFEC, 32'd3,
                32'hFFFF_FFFE, DIV_STALL, 1'b1);
      issue_mop("div_7_m2", 3'd4, 2'b00, 32'd7, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                DIV_STALL, 1'b0);
      issue_mop("rem_7_m2", 3'd6, 2'b00, 32'd7, 32'h0, 32'hFFFF_FFFE, 32'd1,
                DIV_STALL, 1'b0);
      issue_mop("divu_100_7", 3'd5, 2'b00, 32'd100, 32'h0, 32'd7, 32'd14, DIV_STALL, 1'b0);
      issue_mop("remu_100_7", 3'd7, 2'b00, 32'd100, 32'h0, 32'd7, 32'd2, DIV_STALL, 1'b0);
      issue_mop("divu_max_1", 3'd5, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'hFFFF_FFFF,
                DIV_STALL, 1'b0);
      issue_mop("divu_9_0", 3'd5, 2'b00, 32'd9, 32'h0, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      issue_mop("rem_9_0", 3'd6, 2'b00, 32'd9, 32'h0, 32'd0, 32'd9, 1, 1'b0);
      issue_mop("div_ovf", 3'd4, 2'b00, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                32'h8000_0000, 1, 1'b0);
      issue_mop("rem_ovf", 3'd6, 2'b00, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd0,
                1, 1'b0);

      // Reset in the middle of an iterative divide; no result is expected from it.
      @(posedge clk);
      #1;
      valid_in = 1'b1; aluop_ex = 2'b10; funct7_ex = 7'b0000001; funct3_ex = 3'd5;
      reg_data1_ex = 32'd100; reg_data2_ex = 32'd7;
      for (int i = 0; i < 11; i++) @(negedge clk);
      check("busy_before_reset", {31'b0, stall_ex}, 32'h1);
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      check("midop_reset_stall", {31'b0, stall_ex}, 32'h0);
      check("midop_reset_valid", {31'b0, valid_out}, 32'h0);
      reset = 1'b0;
      issue_base("add_after_reset", 2'b00, 7'h00, 3'd0, 2'b00, 2'b00, 1'b0,
                 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 32'd2);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
